// File: rtl/rv32_pc_gen_mh.sv
// Per-hart PC generator for the barrel pipeline: round-robin issue over idle harts, branch/jump resolve.
// Optional RV32_PCGEN_MISALIGN_EN: misaligned jump/branch targets redirect to TRAP_PC and pulse ex_misalign.

module rv32_pc_gen_mh_hart #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            grant,
  input  logic            resolve,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_pc,
  output logic [XLEN-1:0] pc,
  output logic            in_flight
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      in_flight <= 1'b0;
    end else begin
      if (resolve && wr_en) pc <= wr_pc;
      else if (grant)       pc <= pc + XLEN'(4);
      if (grant)        in_flight <= 1'b1;
      else if (resolve) in_flight <= 1'b0;
    end
  end
endmodule

module rv32_pc_gen_mh #(
  parameter int              XLEN      = 32,
  parameter int              NUM_HARTS = 8,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] TRAP_PC   = XLEN'('h100),
  localparam int             HID_W     = $clog2(NUM_HARTS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_HARTS-1:0] hart_en,
  input  logic                 stall,
  output logic                 issue_valid,
  output logic [HID_W-1:0]     issue_hart,
  output logic [XLEN-1:0]      issue_pc,
  input  logic                 ex_valid,
  input  logic [HID_W-1:0]     ex_hart,
  input  logic [2:0]           ex_kind,
  input  logic                 ex_taken,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [XLEN-1:0]      ex_rs1,
  input  logic [XLEN-1:0]      ex_imm,
  output logic                 ex_save_pc,
  output logic [XLEN-1:0]      ex_link,
  output logic                 ex_redirect,
  output logic                 ex_misalign
);
  localparam logic [2:0] K_BRANCH = 3'd1;
  localparam logic [2:0] K_JAL    = 3'd2;
  localparam logic [2:0] K_JALR   = 3'd3;
  localparam logic [2:0] K_AUIPC  = 3'd4;

  logic [NUM_HARTS-1:0][XLEN-1:0] pc;
  logic [NUM_HARTS-1:0]           in_flight, elig, grant_vec, res_vec;
  logic [HID_W-1:0]               rr_ptr, idx, gnt_hart;
  logic                           gnt_found;
  logic [XLEN-1:0]                target, wr_pc;
  logic                           wr_en, mis;

  assign elig = hart_en & ~in_flight & {NUM_HARTS{~stall}};

  // Walk harts starting at rr_ptr, wrapping at NUM_HARTS (need not be a power of 2).
  always_comb begin
    gnt_found = 1'b0;
    gnt_hart  = '0;
    idx       = rr_ptr;
    for (int i = 0; i < NUM_HARTS; i++) begin
      if (!gnt_found && elig[idx]) begin
        gnt_found = 1'b1;
        gnt_hart  = idx;
      end
      idx = (idx == HID_W'(NUM_HARTS-1)) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    target = ex_pc + ex_imm;
    wr_en  = 1'b0;
    case (ex_kind)
      K_BRANCH: wr_en = ex_valid & ex_taken;
      K_JAL:    wr_en = ex_valid;
      K_JALR: begin
        wr_en  = ex_valid;
        target = (ex_rs1 + ex_imm) & ~XLEN'(1);
      end
      default:  wr_en = 1'b0;
    endcase
  end

`ifdef RV32_PCGEN_MISALIGN_EN
  assign mis   = wr_en & target[1];
  assign wr_pc = mis ? TRAP_PC : target;
`else
  logic unused_trap;
  assign unused_trap = ^TRAP_PC;
  assign mis   = 1'b0;
  assign wr_pc = target;
`endif

  assign ex_save_pc = ex_valid & (ex_kind == K_JAL || ex_kind == K_JALR || ex_kind == K_AUIPC);

  always_comb begin
    case (ex_kind)
      K_JAL, K_JALR: ex_link = ex_pc + XLEN'(4);
      K_AUIPC:       ex_link = ex_pc + ex_imm;
      default:       ex_link = '0;
    endcase
  end

  for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
    assign grant_vec[h] = gnt_found && (gnt_hart == HID_W'(h));
    assign res_vec[h]   = ex_valid && (ex_hart == HID_W'(h));
    rv32_pc_gen_mh_hart #(.XLEN(XLEN), .RESET_PC(RESET_PC)) u_hart (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (grant_vec[h]),
      .resolve   (res_vec[h]),
      .wr_en     (wr_en),
      .wr_pc     (wr_pc),
      .pc        (pc[h]),
      .in_flight (in_flight[h])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      issue_valid <= 1'b0;
      issue_hart  <= '0;
      issue_pc    <= '0;
      ex_redirect <= 1'b0;
      ex_misalign <= 1'b0;
    end else begin
      issue_valid <= gnt_found;
      ex_redirect <= wr_en;
      ex_misalign <= mis;
      if (gnt_found) begin
        issue_hart <= gnt_hart;
        issue_pc   <= pc[gnt_hart];
        rr_ptr     <= (gnt_hart == HID_W'(NUM_HARTS-1)) ? '0 : gnt_hart + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rv32_pc_gen_mh.sv
// Self-checking bench for rv32_pc_gen_mh: directed scenarios plus random traffic vs a behavioural model.
// Honours RV32_PCGEN_MISALIGN_EN for the misaligned-target expectations.

module tb_rv32_pc_gen_mh;
  localparam int NH = 8;
  localparam logic [31:0] TRAP = 32'h100;
`ifdef RV32_PCGEN_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0, rst_n;
  logic [7:0]  hart_en;
  logic        stall, ex_valid, ex_taken;
  logic [2:0]  ex_hart, ex_kind;
  logic [31:0] ex_pc, ex_rs1, ex_imm;
  logic        issue_valid, ex_save_pc, ex_redirect, ex_misalign;
  logic [2:0]  issue_hart;
  logic [31:0] issue_pc, ex_link;

  rv32_pc_gen_mh #(.XLEN(32), .NUM_HARTS(NH), .RESET_PC(32'h0), .TRAP_PC(TRAP)) dut (
    .clk(clk), .rst_n(rst_n), .hart_en(hart_en), .stall(stall),
    .issue_valid(issue_valid), .issue_hart(issue_hart), .issue_pc(issue_pc),
    .ex_valid(ex_valid), .ex_hart(ex_hart), .ex_kind(ex_kind), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_imm(ex_imm),
    .ex_save_pc(ex_save_pc), .ex_link(ex_link),
    .ex_redirect(ex_redirect), .ex_misalign(ex_misalign)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Behavioural model: architectural PCs, busy flags, pointer, expected registered outputs.
  logic [31:0] m_pc [NH];
  bit          m_if [NH];
  int          m_rr;
  bit          e_iv, e_redir, e_mis;
  int          e_ih;
  logic [31:0] e_ipc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_link(input int kind, input logic [31:0] pc, input logic [31:0] imm);
    if (kind == 2 || kind == 3) return pc + 32'd4;
    if (kind == 4) return pc + imm;
    return 32'h0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NH; i++) begin m_pc[i] = 32'h0; m_if[i] = 1'b0; end
    m_rr = 0; e_iv = 0; e_ih = 0; e_ipc = 0; e_redir = 0; e_mis = 0;
  endtask

  task automatic model_step();
    int g, h;
    bit w;
    logic [31:0] t;
    g = -1;
    if (!stall)
      for (int i = 0; i < NH; i++) begin
        h = (m_rr + i) % NH;
        if (g < 0 && hart_en[h] && !m_if[h]) g = h;
      end
    e_redir = 0; e_mis = 0;
    if (g >= 0) begin
      e_iv = 1; e_ih = g; e_ipc = m_pc[g];
      m_pc[g] = m_pc[g] + 32'd4; m_if[g] = 1; m_rr = (g + 1) % NH;
    end else e_iv = 0;
    if (ex_valid) begin
      w = 0; t = 0;
      case (ex_kind)
        3'd1: if (ex_taken) begin w = 1; t = ex_pc + ex_imm; end
        3'd2: begin w = 1; t = ex_pc + ex_imm; end
        3'd3: begin w = 1; t = (ex_rs1 + ex_imm) & ~32'd1; end
        default: w = 0;
      endcase
      m_if[ex_hart] = 0;
      if (w) begin
        e_redir = 1;
        if (MIS && t[1]) begin e_mis = 1; t = TRAP; end
        m_pc[ex_hart] = t;
      end
    end
  endtask

  task automatic compare_regs();
    chk("issue_valid", {31'b0, issue_valid}, {31'b0, e_iv});
    chk("issue_hart",  {29'b0, issue_hart},  32'(e_ih));
    chk("issue_pc",    issue_pc,             e_ipc);
    chk("ex_redirect", {31'b0, ex_redirect}, {31'b0, e_redir});
    chk("ex_misalign", {31'b0, ex_misalign}, {31'b0, e_mis});
  endtask

  // Called at a negedge; returns at the following negedge with registered outputs checked.
  task automatic step(input logic [7:0] en, input bit st, input bit v, input int hart, input int kind,
                      input bit tk, input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] imm);
    bit sv;
    hart_en = en; stall = st; ex_valid = v; ex_hart = 3'(hart); ex_kind = 3'(kind);
    ex_taken = tk; ex_pc = pc; ex_rs1 = rs1; ex_imm = imm;
    #1;
    sv = v && (kind == 2 || kind == 3 || kind == 4);
    chk("ex_save_pc", {31'b0, ex_save_pc}, {31'b0, sv});
    if (v) chk("ex_link", ex_link, exp_link(kind, pc, imm));
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_regs();
  endtask

  task automatic idle(input logic [7:0] en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    int first, pick, nin;
    int inq[$];
    logic [7:0] en;
    logic [31:0] imms[6];
    imms = '{32'h4, 32'h6, 32'hFFFF_FFF0, 32'h20, 32'h2, 32'h8000_0000};

    rst_n = 1'b0; hart_en = '0; stall = 0; ex_valid = 0; ex_hart = 0; ex_kind = 0;
    ex_taken = 0; ex_pc = 0; ex_rs1 = 0; ex_imm = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk("rst issue_valid", {31'b0, issue_valid}, 32'h0);
    chk("rst issue_hart",  {29'b0, issue_hart},  32'h0);
    chk("rst issue_pc",    issue_pc,             32'h0);
    chk("rst ex_redirect", {31'b0, ex_redirect}, 32'h0);
    chk("rst ex_misalign", {31'b0, ex_misalign}, 32'h0);
    rst_n = 1'b1;

    // All harts enabled: h0..h7 at pc 0, then silence.
    for (int i = 0; i < NH; i++) begin
      idle(8'hFF, 1);
      chk("init valid", {31'b0, issue_valid}, 32'h1);
      chk("init hart",  {29'b0, issue_hart},  32'(i));
      chk("init pc",    issue_pc,             32'h0);
    end
    idle(8'hFF, 1);
    chk("all busy valid", {31'b0, issue_valid}, 32'h0);

    step(8'hFF, 0, 1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    chk("none same cyc valid", {31'b0, issue_valid}, 32'h0);
    idle(8'hFF, 1);
    chk("h0 reissue hart", {29'b0, issue_hart}, 32'h0);
    chk("h0 reissue pc",   issue_pc,            32'h4);

    // Park h3 at 0x40, then branch not-taken / taken.
    step(8'hFF, 0, 1, 3, 2, 0, 32'h0, 32'h0, 32'h40);
    idle(8'hFF, 1);
    chk("h3 jal pc", issue_pc, 32'h40);
    step(8'hFF, 0, 1, 3, 1, 0, 32'h40, 32'h0, 32'h20);
    chk("nt redirect", {31'b0, ex_redirect}, 32'h0);
    idle(8'hFF, 1);
    chk("nt pc", issue_pc, 32'h44);
    step(8'hFF, 0, 1, 3, 1, 1, 32'h40, 32'h0, 32'h20);
    chk("tk redirect", {31'b0, ex_redirect}, 32'h1);
    idle(8'hFF, 1);
    chk("tk hart", {29'b0, issue_hart}, 32'h3);
    chk("tk pc",   issue_pc,            32'h60);
    chk("tk redirect drop", {31'b0, ex_redirect}, 32'h0);

    step(8'hFF, 0, 1, 1, 3, 0, 32'h80, 32'h1001, 32'h10);
    chk("jalr save", {31'b0, ex_save_pc}, 32'h1);
    chk("jalr link", ex_link, 32'h84);
    idle(8'hFF, 1);
    chk("jalr pc", issue_pc, 32'h1010);
    step(8'hFF, 0, 1, 2, 4, 0, 32'h80, 32'h0, 32'h3000);
    chk("auipc link", ex_link, 32'h3080);
    chk("auipc redirect", {31'b0, ex_redirect}, 32'h0);
    idle(8'hFF, 1);

    // Stall while resolving everything: no issue; release resumes from saved pointer.
    for (int h = 0; h < NH; h++) begin
      step(8'hFF, 1, 1, h, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("stall valid", {31'b0, issue_valid}, 32'h0);
    end
    for (int i = 0; i < 2; i++) begin
      step(8'hFF, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      chk("stall idle valid", {31'b0, issue_valid}, 32'h0);
    end
    first = m_rr;
    for (int i = 0; i < NH; i++) begin
      idle(8'hFF, 1);
      chk("resume hart", {29'b0, issue_hart}, 32'((first + i) % NH));
    end

    step(8'hFF, 0, 1, 2, 2, 0, 32'h10, 32'h0, 32'h6);
    chk("mis pulse", {31'b0, ex_misalign}, {31'b0, MIS});
    chk("mis redirect", {31'b0, ex_redirect}, 32'h1);
    idle(8'hFF, 1);
    chk("mis pc", issue_pc, MIS ? TRAP : 32'h16);

    // Disabled hart: in-flight resolve and idle resolve both land, no issue until re-enabled.
    step(8'hDF, 0, 1, 5, 2, 0, 32'h100, 32'h0, 32'h100);
    idle(8'hDF, 3);
    chk("disabled no issue", {31'b0, issue_valid}, 32'h0);
    step(8'hDF, 0, 1, 5, 2, 0, 32'h0, 32'h0, 32'h300);
    idle(8'hFF, 1);
    chk("reenable hart", {29'b0, issue_hart}, 32'h5);
    chk("reenable pc",   issue_pc,            32'h300);

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      en = 8'h0;
      for (int i = 0; i < NH; i++) en[i] = ($urandom_range(3) != 0);
      inq.delete();
      for (int i = 0; i < NH; i++) if (m_if[i]) inq.push_back(i);
      pick = -1;
      if (inq.size() > 0 && $urandom_range(2) != 0) pick = inq[$urandom_range(inq.size() - 1)];
      else if ($urandom_range(9) == 0) begin
        nin = -1;
        for (int i = 0; i < NH; i++) if (!en[i] && !m_if[i]) nin = i;
        pick = nin;
      end
      step(en, ($urandom_range(7) == 0), (pick >= 0), (pick >= 0) ? pick : 0, int'($urandom_range(7)),
           1'($urandom), ($urandom_range(7) == 0) ? 32'hFFFF_FFFC : {$urandom_range(32'h3FFF_FFFF), 2'b00},
           $urandom, imms[$urandom_range(5)]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
